// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system ID slave (address 0: ID, address 1: build
// timestamp) and checks both words, with retries and an optional periodic recheck.
// Checks run after reset, on start, and on recheck expiry; results are held until the next check.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1363016929,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned RETRY_GAP      = 16,
  parameter int unsigned RECHECK_PERIOD = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [3:0]  attempts
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, COMPARE, GAP, DONE} state_t;

  localparam logic [4:0]  MAX_R    = 5'(MAX_RETRIES);
  localparam logic [7:0]  GAP_LOAD = 8'(RETRY_GAP - 1);
  localparam logic [23:0] RC_LOAD  = 24'(RECHECK_PERIOD);
  localparam bit          RC_EN    = (RECHECK_PERIOD != 0);

  state_t      state;
  // Attempt count kept one bit wider than the output so MAX_RETRIES=15 still terminates.
  logic [4:0]  tries;
  logic [4:0]  tries_inc;
  logic [7:0]  gap_cnt;
  logic [23:0] rc_cnt;
  logic        rc_expired;
  logic        id_ok;
  logic        ts_ok;
  logic        go;

  assign tries_inc  = tries + 5'd1;
  assign rc_expired = RC_EN && (rc_cnt == 24'd0);
  assign id_ok      = (captured_id == EXPECTED_ID);
  assign ts_ok      = (captured_ts == EXPECTED_TS);
  // IDLE is only reachable through reset, so it always launches the auto-start check.
  // start and recheck expiry in the same cycle collapse into one check.
  assign go = (state == IDLE) || ((state == DONE) && (start || rc_expired));

  // Check sequencer: all outputs are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tries       <= 5'd0;
      gap_cnt     <= 8'd0;
      rc_cnt      <= 24'd0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
      attempts    <= 4'd0;
    end else if (go) begin
      state       <= RD_ID;
      tries       <= 5'd1;
      attempts    <= 4'd1;
      avm_address <= 1'b0;
      avm_read    <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
    end else begin
      case (state)
        RD_ID: begin
          if (!avm_waitrequest) begin
            captured_id <= avm_readdata;
            avm_address <= 1'b1;
            state       <= RD_TS;
          end
        end
        RD_TS: begin
          if (!avm_waitrequest) begin
            captured_ts <= avm_readdata;
            avm_read    <= 1'b0;
            state       <= COMPARE;
          end
        end
        COMPARE: begin
          id_mismatch <= !id_ok;
          ts_mismatch <= !ts_ok;
          if (id_ok && ts_ok) begin
            state  <= DONE;
            done   <= 1'b1;
            pass   <= 1'b1;
            busy   <= 1'b0;
            rc_cnt <= RC_LOAD;
          end else if (tries <= MAX_R) begin
            tries    <= tries_inc;
            attempts <= (tries_inc > 5'd15) ? 4'd15 : tries_inc[3:0];
            gap_cnt  <= GAP_LOAD;
            state    <= GAP;
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            pass   <= 1'b0;
            busy   <= 1'b0;
            rc_cnt <= RC_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            avm_address <= 1'b0;
            avm_read    <= 1'b1;
            state       <= RD_ID;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DONE: begin
          if (RC_EN && (rc_cnt != 24'd0)) rc_cnt <= rc_cnt - 24'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: table of full-check scenarios plus hand sequences
// for start handling, periodic recheck and asynchronous reset during a read.
module tb_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1363016929;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch;
  logic [31:0] captured_id, captured_ts;
  logic [3:0]  attempts;

  // Slave model controls
  int          wait_n;
  bit          bad_id;
  logic [31:0] ts_word;
  int          stall_cnt;
  int          id_acc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sysid_checker #(.RECHECK_PERIOD(100)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .pass(pass),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch),
    .captured_id(captured_id), .captured_ts(captured_ts), .attempts(attempts)
  );

  // Stall the first wait_n address-0 cycles; optionally return a bad ID on the first accepted read.
  assign avm_waitrequest = avm_read && !avm_address && (stall_cnt < wait_n);
  assign avm_readdata    = avm_address ? ts_word : ((bad_id && id_acc == 0) ? 32'd5 : 32'd0);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 0;
      id_acc    <= 0;
    end else if (avm_read && !avm_address) begin
      if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
      else                 id_acc    <= id_acc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Count rising edges until done is seen (sampled 1 time unit after each edge).
  task automatic run_to_done(output int cyc, output int rd0, output int rd1);
    cyc = -1; rd0 = 0; rd1 = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock); #1;
      if (avm_read && !avm_address) rd0++;
      if (avm_read &&  avm_address) rd1++;
      if (done) begin cyc = k; break; end
    end
  endtask

  task automatic reset_and_release();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    int          wait_n;
    bit          bad_id;
    logic [31:0] ts_word;
    bit          exp_pass;
    int          exp_att;
    bit          exp_idm;
    bit          exp_tsm;
    int          exp_cyc;
    int          exp_rd0;
    int          exp_rd1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc, rd0, rd1, k;
    reset_n = 1'b0; start = 1'b0; wait_n = 0; bad_id = 1'b0; ts_word = TS_OK;

    vecs[0] = '{"clean",     0, 1'b0, TS_OK, 1'b1, 1, 1'b0, 1'b0,  4, 1, 1};
    vecs[1] = '{"wait3",     3, 1'b0, TS_OK, 1'b1, 1, 1'b0, 1'b0,  7, 4, 1};
    vecs[2] = '{"ts_bad",    0, 1'b0, 32'd0, 1'b0, 4, 1'b0, 1'b1, 61, 4, 4};
    vecs[3] = '{"id_retry",  0, 1'b1, TS_OK, 1'b1, 2, 1'b0, 1'b0, 23, 2, 2};

    // Reset state
    #12;
    check("rst_read",  {31'd0, avm_read}, 0);
    check("rst_flags", {26'd0, busy, done, pass, id_mismatch, ts_mismatch, avm_address}, 0);
    check("rst_cap",   captured_id | captured_ts, 0);
    check("rst_att",   {28'd0, attempts}, 0);

    // Table-driven full checks from reset release
    for (int i = 0; i < 4; i++) begin
      reset_n = 1'b0;
      wait_n = vecs[i].wait_n; bad_id = vecs[i].bad_id; ts_word = vecs[i].ts_word;
      reset_and_release();
      run_to_done(cyc, rd0, rd1);
      check({vecs[i].name, "_cyc"},  cyc, vecs[i].exp_cyc);
      check({vecs[i].name, "_pass"}, {31'd0, pass}, {31'd0, vecs[i].exp_pass});
      check({vecs[i].name, "_att"},  {28'd0, attempts}, vecs[i].exp_att);
      check({vecs[i].name, "_idm"},  {31'd0, id_mismatch}, {31'd0, vecs[i].exp_idm});
      check({vecs[i].name, "_tsm"},  {31'd0, ts_mismatch}, {31'd0, vecs[i].exp_tsm});
      check({vecs[i].name, "_busy"}, {31'd0, busy}, 0);
      check({vecs[i].name, "_cid"},  captured_id, 0);
      check({vecs[i].name, "_cts"},  captured_ts, vecs[i].ts_word);
      check({vecs[i].name, "_rd0"},  rd0, vecs[i].exp_rd0);
      check({vecs[i].name, "_rd1"},  rd1, vecs[i].exp_rd1);
    end

    // start during RD_TS is ignored
    wait_n = 0; bad_id = 1'b0; ts_word = TS_OK;
    reset_and_release();
    @(posedge clock); #1;             // RD_ID
    @(posedge clock); #1;             // RD_TS
    check("rdts_state_read", {30'd0, avm_read, avm_address}, 3);
    start = 1'b1;
    @(posedge clock); #1;             // sampled in RD_TS
    start = 1'b0;
    run_to_done(cyc, rd0, rd1);
    check("ign_cyc", cyc, 1);
    for (int j = 0; j < 30; j++) begin
      @(posedge clock); #1;
      if (avm_read) rd0++;
    end
    check("ign_noreread", rd0, 0);
    check("ign_done_held", {30'd0, done, pass}, 3);

    // start in DONE launches a new check
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("restart_done_low", {31'd0, done}, 0);
    check("restart_busy_read", {29'd0, busy, avm_read, avm_address}, 3'b110);
    check("restart_att", {28'd0, attempts}, 1);
    run_to_done(cyc, rd0, rd1);
    check("restart_cyc", cyc, 3);
    check("restart_pass", {31'd0, pass}, 1);

    // Periodic recheck: next RD_ID 101 cycles after DONE entry
    reset_and_release();
    run_to_done(cyc, rd0, rd1);
    check("rc_first_cyc", cyc, 4);
    k = -1;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clock); #1;
      if (avm_read) begin k = j; break; end
    end
    check("rc_delay", k, 101);
    check("rc_done_cleared", {31'd0, done}, 0);

    // Asynchronous reset in the middle of a stalled RD_ID
    wait_n = 10;
    reset_and_release();
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mid_read_high", {30'd0, avm_read, busy}, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_read", {31'd0, avm_read}, 0);
    check("mid_rst_outs", {27'd0, busy, done, pass, id_mismatch, ts_mismatch} | {28'd0, attempts}, 0);
    check("mid_rst_cap", captured_id | captured_ts, 0);
    wait_n = 0;
    @(negedge clock);
    reset_n = 1'b1;
    run_to_done(cyc, rd0, rd1);
    check("mid_restart_cyc", cyc, 4);
    check("mid_restart_pass", {31'd0, pass}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
